adc_sample_fifo: RTL and testbench
==================================

Name: adc_sample_fifo

Overview:
- Single-clock synchronous FIFO that buffers 16-bit AD7760 conversion words between the ADC capture state machine (writer) and the downstream serial/UART reader.
- Provides registered read data, empty/full flags and fill-level counts on both its write-side and read-side ports.
- Replaces the dual-clock buffer in the ADC path; writer and reader share one clock.

Parameters:
- DATA_WIDTH, 16, width of data and q.
- DEPTH, 256, number of storage words; must be a power of two, minimum 4.
- ADDR_WIDTH, 8, log2(DEPTH); the usedw ports are ADDR_WIDTH+1 bits wide.

Ports:
- mclk  input  1  sole clock; all state updates on its rising edge.
- aclr  input  1  asynchronous, active-high reset; clears all state immediately.
- data  input  DATA_WIDTH  write data, sampled at the mclk edge when the write is accepted.
- wrreq  input  1  write request.
- rdreq  input  1  read request.
- q  output  DATA_WIDTH  registered read data.
- rdempty  output  1  FIFO empty (read-side view).
- rdfull  output  1  FIFO full (read-side view).
- rdusedw  output  ADDR_WIDTH+1  stored word count (read-side view).
- wrempty  output  1  FIFO empty (write-side view).
- wrfull  output  1  FIFO full (write-side view).
- wrusedw  output  ADDR_WIDTH+1  stored word count (write-side view).

Behaviour:
- Storage: DEPTH x DATA_WIDTH array, write pointer, read pointer and word count; all registers.
- Pointers are ADDR_WIDTH bits and wrap from DEPTH-1 to 0.
- count ranges 0..DEPTH.
- Flags and counts derive from count and are glitch-free registered values:
  - empty = (count==0); full = (count==DEPTH).
  - rdempty = wrempty = empty; rdfull = wrfull = full.
  - rdusedw = wrusedw = count.
- Reset (aclr=1, asynchronous): pointers=0, count=0, q=0, empty=1, full=0, usedw=0.
  - Memory contents need not be cleared.
  - Reset mid-operation discards all stored words; the first read after reset returns the first word written after reset.
- Write accept: wrreq=1 and full=0.
  - mem[wrptr] <= data; wrptr increments.
- Read accept: rdreq=1 and empty=0.
  - q <= mem[rdptr]; rdptr increments.
  - Read latency is 1 cycle: the word appears on q after the accepting edge.
  - q holds its last value when no read is accepted.
- Count update: +1 on accepted write only; -1 on accepted read only; unchanged when both or neither are accepted.
- Overflow protection: wrreq while full is ignored, even if rdreq is also asserted that cycle. No data is corrupted and count stays DEPTH (a read still occurs if requested).
- Underflow protection: rdreq while empty is ignored; q and count are unchanged.
- Empty with simultaneous wrreq and rdreq: the write is accepted, the read is ignored, and count becomes 1.
- Partially filled with simultaneous wrreq and rdreq: both are accepted, count is unchanged, and ordering is preserved (oldest word read first).
- Ordering is strictly FIFO across pointer wrap-around.
- No combinational path from inputs to outputs.

Test Plan:
- Reset: assert aclr mid-cycle with 5 words stored -> immediately rdempty=wrempty=1, full=0, usedw=0, q=0. After release, write 0x1234 and read -> q=0x1234 one cycle after the read edge.
- Fill/drain: write 0x0000..0x00FF (256 words) -> wrfull=rdfull=1 and usedw=256. A 257th write of 0xBEEF is ignored. Read 256 times -> q sequence 0x0000..0x00FF, then empty=1 and usedw=0.
- Underflow: rdreq held 3 cycles while empty -> q unchanged, usedw stays 0, empty stays 1.
- Simultaneous read and write:
  - With 10 words stored, wrreq+rdreq for 20 cycles -> usedw stays 10 and read data is in write order.
  - While empty, one wrreq+rdreq cycle -> usedw=1 and q unchanged.
  - While full, one wrreq+rdreq cycle -> one word is read, the write is dropped, and usedw=255.
- Wrap-around: repeatedly write 200 and read 200 words three times (pointers wrap) -> no data loss or reorder; usedw returns to 0 each time.
- Flag timing: the single write into an empty FIFO -> empty deasserts and usedw=1 at the same edge the write is accepted.

Source files
------------

// File: rtl/adc_sample_fifo.sv
// ---------------------------------------------------------------------------
// adc_sample_fifo
//
// Single-clock synchronous FIFO that buffers AD7760 conversion words between
// the ADC capture state machine (writer) and the serial/UART reader.
// The read data, the flags and the fill counts are all registered.
//
// Ports:
//   mclk     - sole clock; all state updates on its rising edge
//   aclr     - asynchronous active-high clear of all state (memory excluded)
//   data     - write data, captured when a write is accepted
//   wrreq    - write request (ignored while full)
//   rdreq    - read request (ignored while empty)
//   q        - registered read data, valid one cycle after an accepted read
//   rdempty  - empty flag, read-side view
//   rdfull   - full flag, read-side view
//   rdusedw  - stored word count, read-side view
//   wrempty  - empty flag, write-side view
//   wrfull   - full flag, write-side view
//   wrusedw  - stored word count, write-side view
// ---------------------------------------------------------------------------
module adc_sample_fifo #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 256,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  mclk,
  input  logic                  aclr,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  wrreq,
  input  logic                  rdreq,
  output logic [DATA_WIDTH-1:0] q,
  output logic                  rdempty,
  output logic                  rdfull,
  output logic [ADDR_WIDTH:0]   rdusedw,
  output logic                  wrempty,
  output logic                  wrfull,
  output logic [ADDR_WIDTH:0]   wrusedw
);

  localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = 1;
  localparam logic [ADDR_WIDTH:0]   CNT_ONE   = 1;
  localparam logic [ADDR_WIDTH:0]   CNT_FULL  = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   CNT_EMPTY = '0;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wrptr;
  logic [ADDR_WIDTH-1:0] rdptr;
  logic [ADDR_WIDTH:0]   count;
  logic [ADDR_WIDTH:0]   count_next;
  logic                  empty;
  logic                  full;
  logic                  wr_accept;
  logic                  rd_accept;

  // Accept decisions use the registered flags, so a write while full is
  // dropped even when a read frees a slot in the same cycle, and a read while
  // empty is dropped even when a write arrives in the same cycle.
  assign wr_accept = wrreq & ~full;
  assign rd_accept = rdreq & ~empty;

  always_comb begin
    count_next = count;
    case ({wr_accept, rd_accept})
      2'b10:   count_next = count + CNT_ONE;
      2'b01:   count_next = count - CNT_ONE;
      default: count_next = count;
    endcase
  end

  // Flags are registered from the next count so they change on the same edge
  // as the count itself, without any decode glitches on the outputs.
  always_ff @(posedge mclk or posedge aclr) begin
    if (aclr) begin
      wrptr <= '0;
      rdptr <= '0;
      count <= '0;
      empty <= 1'b1;
      full  <= 1'b0;
      q     <= '0;
    end else begin
      count <= count_next;
      empty <= (count_next == CNT_EMPTY);
      full  <= (count_next == CNT_FULL);
      if (wr_accept) begin
        wrptr <= wrptr + PTR_ONE;
      end
      if (rd_accept) begin
        rdptr <= rdptr + PTR_ONE;
        q     <= mem[rdptr];
      end
    end
  end

  // Storage has no reset; stale words are unreachable once the pointers clear.
  always_ff @(posedge mclk) begin
    if (wr_accept) begin
      mem[wrptr] <= data;
    end
  end

  assign rdempty = empty;
  assign wrempty = empty;
  assign rdfull  = full;
  assign wrfull  = full;
  assign rdusedw = count;
  assign wrusedw = count;

endmodule

// File: tb/tb_adc_sample_fifo.sv
// ---------------------------------------------------------------------------
// tb_adc_sample_fifo
//
// Self-checking bench for adc_sample_fifo: a table of short vectors with
// hand-computed expectations, directed multi-cycle sequences and a random
// phase, all checked against a queue-based reference model.
// ---------------------------------------------------------------------------
module tb_adc_sample_fifo;

  localparam int DW    = 16;
  localparam int DEPTH = 256;
  localparam int AW    = 8;

  logic          mclk;
  logic          aclr;
  logic [DW-1:0] data;
  logic          wrreq;
  logic          rdreq;
  logic [DW-1:0] q;
  logic          rdempty;
  logic          rdfull;
  logic [AW:0]   rdusedw;
  logic          wrempty;
  logic          wrfull;
  logic [AW:0]   wrusedw;

  adc_sample_fifo #(
    .DATA_WIDTH(DW),
    .DEPTH     (DEPTH),
    .ADDR_WIDTH(AW)
  ) dut (
    .mclk   (mclk),
    .aclr   (aclr),
    .data   (data),
    .wrreq  (wrreq),
    .rdreq  (rdreq),
    .q      (q),
    .rdempty(rdempty),
    .rdfull (rdfull),
    .rdusedw(rdusedw),
    .wrempty(wrempty),
    .wrfull (wrfull),
    .wrusedw(wrusedw)
  );

  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  typedef struct {
    logic          wr;
    logic          rd;
    logic [DW-1:0] d;
    logic [DW-1:0] exp_q;
    int            exp_cnt;
  } vec_t;

  int            vectors;
  int            miscompares;
  logic [DW-1:0] model_fifo[$];
  logic [DW-1:0] model_q;

  // Reference model: a plain queue; reads pop the oldest word, writes push.
  task automatic model_step(input logic wr, input logic rd, input logic [DW-1:0] d);
    bit wr_ok;
    bit rd_ok;
    wr_ok = wr && (model_fifo.size() < DEPTH);
    rd_ok = rd && (model_fifo.size() > 0);
    if (rd_ok) model_q = model_fifo.pop_front();
    if (wr_ok) model_fifo.push_back(d);
  endtask

  task automatic model_reset();
    model_fifo.delete();
    model_q = '0;
  endtask

  task automatic checkOutput(input string name, input logic [DW-1:0] exp_q, input int exp_cnt);
    logic exp_empty;
    logic exp_full;
    exp_empty = (exp_cnt == 0);
    exp_full  = (exp_cnt == DEPTH);
    vectors++;
    if (q !== exp_q || rdempty !== exp_empty || wrempty !== exp_empty ||
        rdfull !== exp_full || wrfull !== exp_full ||
        rdusedw !== (AW+1)'(exp_cnt) || wrusedw !== (AW+1)'(exp_cnt)) begin
      miscompares++;
      $display("[TB] FAIL %s: got q=%h empty=%b/%b full=%b/%b usedw=%0d/%0d, expected q=%h empty=%b full=%b usedw=%0d",
               name, q, rdempty, wrempty, rdfull, wrfull, rdusedw, wrusedw,
               exp_q, exp_empty, exp_full, exp_cnt);
    end
  endtask

  task automatic checkModel(input string name);
    checkOutput(name, model_q, model_fifo.size());
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
  task automatic applyStimulus(input logic wr, input logic rd, input logic [DW-1:0] d);
    wrreq = wr;
    rdreq = rd;
    data  = d;
    @(posedge mclk);
    #1;
    model_step(wr, rd, d);
    wrreq = 1'b0;
    rdreq = 1'b0;
  endtask

  vec_t vec_table[9];

  initial begin
    vectors     = 0;
    miscompares = 0;
    aclr  = 1'b1;
    wrreq = 1'b0;
    rdreq = 1'b0;
    data  = '0;
    model_reset();

    vec_table[0] = '{1'b1, 1'b0, 16'h0011, 16'h0000, 1};
    vec_table[1] = '{1'b1, 1'b0, 16'h0022, 16'h0000, 2};
    vec_table[2] = '{1'b0, 1'b1, 16'h0000, 16'h0011, 1};
    vec_table[3] = '{1'b1, 1'b1, 16'h0033, 16'h0022, 1};
    vec_table[4] = '{1'b0, 1'b1, 16'h0000, 16'h0033, 0};
    vec_table[5] = '{1'b0, 1'b1, 16'h0000, 16'h0033, 0};
    vec_table[6] = '{1'b1, 1'b1, 16'h0044, 16'h0033, 1};
    vec_table[7] = '{1'b0, 1'b0, 16'h0000, 16'h0033, 1};
    vec_table[8] = '{1'b0, 1'b1, 16'h0000, 16'h0044, 0};

    repeat (2) @(posedge mclk);
    #1;
    checkOutput("reset_state", 16'h0000, 0);
    aclr = 1'b0;

    // Table-driven short vectors from the reset state.
    for (int i = 0; i < 9; i++) begin
      applyStimulus(vec_table[i].wr, vec_table[i].rd, vec_table[i].d);
      checkOutput($sformatf("table_%0d", i), vec_table[i].exp_q, vec_table[i].exp_cnt);
    end

    // Underflow: three reads while empty leave everything unchanged.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, 16'h0000);
      checkOutput("underflow", 16'h0044, 0);
    end

    // Mid-cycle asynchronous reset with 5 words stored.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b0, 16'h0A00 + 16'(i));
    end
    applyStimulus(1'b0, 1'b1, 16'h0000);
    checkModel("pre_reset_read");
    #2;
    aclr = 1'b1;
    #1;
    model_reset();
    checkOutput("async_reset_immediate", 16'h0000, 0);
    @(posedge mclk);
    #1;
    aclr = 1'b0;
    applyStimulus(1'b1, 1'b0, 16'h1234);
    checkOutput("post_reset_write", 16'h0000, 1);
    applyStimulus(1'b0, 1'b1, 16'h0000);
    checkOutput("post_reset_read", 16'h1234, 0);

    // Fill to full, attempt overflow, then drain in order.
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b1, 1'b0, 16'(i));
      checkModel("fill");
    end
    checkOutput("full_reached", 16'h1234, DEPTH);
    applyStimulus(1'b1, 1'b0, 16'hBEEF);
    checkOutput("overflow_ignored", 16'h1234, DEPTH);
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b0, 1'b1, 16'h0000);
      checkOutput("drain", 16'(i), DEPTH - 1 - i);
    end

    // Simultaneous read/write with 10 words stored.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 1'b0, 16'h1000 + 16'(i));
    end
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, 1'b1, 16'h1000 + 16'(10 + i));
      checkOutput("simul_partial", 16'h1000 + 16'(i), 10);
    end
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 1'b1, 16'h0000);
      checkModel("simul_drain");
    end

    // Simultaneous read/write while full: read happens, write is dropped.
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b1, 1'b0, 16'h2000 + 16'(i));
    end
    applyStimulus(1'b1, 1'b1, 16'hDEAD);
    checkOutput("simul_full", 16'h2000, DEPTH - 1);
    for (int i = 0; i < DEPTH - 1; i++) begin
      applyStimulus(1'b0, 1'b1, 16'h0000);
      checkModel("full_drain");
    end
    checkOutput("full_drain_end", 16'h2000 + 16'(DEPTH - 1), 0);

    // Wrap-around: three rounds of 200 writes then 200 reads.
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 200; i++) begin
        applyStimulus(1'b1, 1'b0, 16'($urandom));
      end
      for (int i = 0; i < 200; i++) begin
        applyStimulus(1'b0, 1'b1, 16'h0000);
        checkModel("wrap_read");
      end
      checkModel("wrap_round_end");
    end

    // Randomized traffic against the model, with write/read bias phases.
    for (int i = 0; i < 3000; i++) begin
      int bias;
      bias = (i / 500) % 3;
      applyStimulus($urandom_range(0, 99) < (bias == 0 ? 80 : (bias == 1 ? 20 : 50)),
                    $urandom_range(0, 99) < (bias == 0 ? 20 : (bias == 1 ? 80 : 50)),
                    16'($urandom));
      checkModel("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
